rr_arbiter7: RTL and testbench
==============================

// Module: rr_arbiter7
// PURPOSE
//  7-requester round-robin arbiter for the shared memory/bus port of the processor datapath.
//  Grants exactly one requester at a time with fair rotating priority and a bounded hold time.
//  Raw requests are reduced by a 7-input OR to detect activity.
//  The winner is driven as a registered one-hot grant plus an encoded ID to the port mux.
// PARAMETERS
//  N_REQ     7   number of requesters; fixed at 7, other values unsupported
//  MAX_HOLD  8   max consecutive cycles one owner may hold the grant; must be >= 1
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous, active-low reset
//  req        in   7  request per requester; held high while the requester wants/uses the port
//  lock       in   1  owner requests extended hold (present only with ARB_LOCK_EN)
//  gnt        out  7  registered one-hot grant; all zero when idle
//  gnt_id     out  3  encoded index of the current owner; 0 when idle
//  gnt_valid  out  1  high when any grant is active (equals |gnt)
//  any_req    out  1  combinational OR of req[6:0]
// BEHAVIOUR
//  - Reset (async, rst_n=0): gnt=0, gnt_id=0, gnt_valid=0, hold_cnt=0, state=IDLE.
//    Priority pointer last=6, so requester 0 wins first. Takes effect immediately, even mid-grant.
//  - States: IDLE, GRANT. Internal: last[2:0], hold_cnt[$clog2(MAX_HOLD+1)-1:0].
//  - Arbitration: winner is the first requester with req=1, searching last+1, last+2, ... cyclically mod 7.
//    When the winner is granted, last <= winner and hold_cnt <= 1.
//  - IDLE: any_req=1 at an edge -> GRANT to the winner at that edge. Latency is 1 clk from req to gnt.
//    any_req=0 -> stay in IDLE.
//  - GRANT, owner keeps grant: req[owner]=1 and hold_cnt<MAX_HOLD -> hold_cnt++; gnt unchanged.
//  - GRANT, release: req[owner]=0 at an edge.
//    Other requests pending -> the new winner is granted at that same edge (no bubble).
//    None pending -> IDLE, gnt=0 next cycle.
//  - GRANT, timeout: req[owner]=1 and hold_cnt==MAX_HOLD.
//    Arbitrate with the owner excluded; a winner is granted at that edge.
//    Owner is the sole requester -> owner retains the grant, hold_cnt <= 1, last unchanged.
//  - Non-owner requests rising or falling mid-grant do not affect gnt.
//  - Invariants: gnt always one-hot or zero; gnt_id matches gnt; gnt_valid == |gnt.
//  - X on req is not tolerated; the bench drives only 0/1.
// CONFIGURATION
//  ARB_LOCK_EN defined:
//  - Port lock exists. While lock=1 and req[owner]=1, the timeout is suppressed.
//  - hold_cnt saturates at MAX_HOLD. Release on req[owner]=0 still applies.
//  - If lock drops while hold_cnt==MAX_HOLD, timeout arbitration happens at the next edge.
//  ARB_LOCK_EN undefined:
//  - No lock port. The MAX_HOLD timeout is always enforced.
// TESTING
//  1 Reset: rst_n=0, req=7'h7F -> gnt=0, gnt_id=0, gnt_valid=0.
//    Release rst_n -> gnt=7'h01 after 1 clk.
//  2 Rotation: req=7'h7F, each owner drops req for 1 clk on grant (MAX_HOLD=8).
//    -> gnt_id sequence 0,1,2,3,4,5,6,0 with no idle cycles.
//  3 Timeout: req=7'h05 held continuously, MAX_HOLD=8.
//    -> gnt=01 for 8 clks, then 04 for 8 clks, then 01.
//  4 Sole requester: req=7'h10 held 20 clks -> gnt=7'h10, gnt_id=4 throughout, no glitch at the timeout edges.
//  5 Async reset mid-grant: assert rst_n=0 between edges while gnt=7'h08.
//    -> gnt=0 immediately. After release, with req=7'h08 -> gnt=7'h08 after 1 clk.
//  6 ARB_LOCK_EN: req=7'h03, owner 0, lock=1 for 20 clks -> gnt=01 for 20 clks.
//    lock=0 -> gnt=02 on the next edge.

Source files
------------

// File: rtl/rr_arbiter7.sv
// 7-requester round-robin arbiter with registered one-hot grant and bounded hold time.
// Optional owner lock that suppresses the hold timeout: define ARB_LOCK_EN.
module rr_arbiter7 #(
  parameter int N_REQ    = 7,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       gnt_id,
  output logic             gnt_valid,
  output logic             any_req
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [2:0]       last;
  logic [HW-1:0]    hold_cnt;

  logic [N_REQ-1:0] cand;
  logic [3:0]       win;
  logic             win_found;
  logic [2:0]       win_id;
  logic             owner_req;
  logic             hold_lock;
  logic             at_max;
  logic             take;
  logic             go_idle;

  // First set bit of r, scanning from one past 'from' and wrapping; MSB of result = found.
  function automatic logic [3:0] pick(input logic [N_REQ-1:0] r, input logic [2:0] from);
    logic [3:0] res;
    int         idx;
    res = 4'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(from) + k) % N_REQ;
      if (r[3'(idx)]) res = {1'b1, 3'(idx)};
    end
    return res;
  endfunction

  assign any_req   = |req;
  assign gnt_valid = |gnt;
  assign owner_req = |(req & gnt);

`ifdef ARB_LOCK_EN
  assign hold_lock = lock & owner_req;
`else
  assign hold_lock = 1'b0;
`endif

  // Excluding the current owner covers idle, release and timeout arbitration alike.
  always_comb begin
    cand      = req & ~gnt;
    win       = pick(cand, last);
    win_found = win[3];
    win_id    = win[2:0];
    at_max    = (hold_cnt >= HW'(MAX_HOLD));
    take      = win_found &&
                ((state == IDLE) || !owner_req || (at_max && !hold_lock));
    go_idle   = (state == GRANT) && !owner_req && !win_found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= 3'd0;
      last     <= 3'd6;
      hold_cnt <= '0;
    end else if (take) begin
      state    <= GRANT;
      gnt      <= N_REQ'(1) << win_id;
      gnt_id   <= win_id;
      last     <= win_id;
      hold_cnt <= HW'(1);
    end else if (go_idle) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= 3'd0;
      hold_cnt <= '0;
    end else if (state == GRANT) begin
      if (!at_max)
        hold_cnt <= hold_cnt + HW'(1);
      else if (!hold_lock)
        hold_cnt <= HW'(1);
    end
  end

endmodule

// File: tb/tb_rr_arbiter7.sv
// Self-checking bench for rr_arbiter7: directed scenarios plus randomized traffic
// compared against a cycle-level round-robin reference model.
module tb_rr_arbiter7;

  localparam int MAXH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] req = 7'h00;
  logic       lock = 1'b0;
  logic [6:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       any_req;

  int total = 0;
  int bad   = 0;

  // reference model state: owner index (-1 when idle), last granted, cycles held
  int m_owner = -1;
  int m_last  = 6;
  int m_cnt   = 0;

  rr_arbiter7 #(.N_REQ(7), .MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
`ifdef ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .any_req  (any_req)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, bench did not complete");
    $fatal(1);
  end

  function automatic int search(input logic [6:0] r, input int from);
    for (int k = 1; k <= 7; k++)
      if (r[(from + k) % 7]) return (from + k) % 7;
    return -1;
  endfunction

  function automatic logic [6:0] m_gnt();
    logic [6:0] v;
    v = 7'h00;
    if (m_owner >= 0) v[m_owner] = 1'b1;
    return v;
  endfunction

  function automatic logic [2:0] m_id();
    return (m_owner >= 0) ? 3'(m_owner) : 3'd0;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 6;
    m_cnt   = 0;
  endtask

  task automatic model_edge(input logic [6:0] r, input logic lk);
    int w;
    logic [6:0] others;
    others = r;
    if (m_owner >= 0) others[m_owner] = 1'b0;
    w = search(others, m_last);
    if (m_owner < 0 || !r[m_owner]) begin
      if (w >= 0) begin m_owner = w; m_last = w; m_cnt = 1; end
      else begin m_owner = -1; m_cnt = 0; end
    end else if (m_cnt < MAXH) begin
      m_cnt = m_cnt + 1;
    end else if (!lk) begin
      if (w >= 0) begin m_owner = w; m_last = w; m_cnt = 1; end
      else m_cnt = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge(req, lock);
  endtask

  task automatic do_reset(input logic [6:0] r);
    rst_n = 1'b0;
    req   = r;
    lock  = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 7'h7F;
    model_reset();
    #2;
    total++; if (gnt !== 7'h00) begin bad++; $display("FAIL reset_gnt: got %h want 00", gnt); end
    total++; if (gnt_id !== 3'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", gnt_id); end
    total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", gnt_valid); end
    total++; if (any_req !== 1'b1) begin bad++; $display("FAIL reset_anyreq: got %b want 1", any_req); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 7'h01) begin bad++; $display("FAIL reset_first: got %h want 01", gnt); end
  endtask

  task automatic test_rotation();
    int cur;
    cur = 0;
    total++; if (gnt_id !== 3'd0) begin bad++; $display("FAIL rot_start: got %0d want 0", gnt_id); end
    for (int i = 0; i < 7; i++) begin
      req = 7'h7F & ~(7'h01 << cur);
      tick();
      cur = (cur + 1) % 7;
      req = 7'h7F;
      total++;
      if (gnt_id !== 3'(cur) || gnt_valid !== 1'b1) begin
        bad++; $display("FAIL rot_step%0d: got id %0d valid %b want id %0d valid 1", i, gnt_id, gnt_valid, cur);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] exp;
    do_reset(7'h05);
    for (int c = 0; c < 17; c++) begin
      tick();
      exp = (c < 8) ? 7'h01 : (c < 16) ? 7'h04 : 7'h01;
      total++;
      if (gnt !== exp) begin bad++; $display("FAIL timeout_c%0d: got %h want %h", c, gnt, exp); end
    end
  endtask

  task automatic test_sole();
    do_reset(7'h10);
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (gnt !== 7'h10 || gnt_id !== 3'd4) begin
        bad++; $display("FAIL sole_c%0d: got gnt %h id %0d want 10 id 4", c, gnt, gnt_id);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(7'h08);
    tick(); tick(); tick();
    total++; if (gnt !== 7'h08) begin bad++; $display("FAIL arst_pre: got %h want 08", gnt); end
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (gnt !== 7'h00 || gnt_valid !== 1'b0) begin
      bad++; $display("FAIL arst_now: got gnt %h valid %b want 00 valid 0", gnt, gnt_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 7'h08) begin bad++; $display("FAIL arst_post: got %h want 08", gnt); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset(7'h03);
    lock = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (gnt !== 7'h01) begin bad++; $display("FAIL lock_c%0d: got %h want 01", c, gnt); end
    end
    lock = 1'b0;
    tick();
    total++; if (gnt !== 7'h02) begin bad++; $display("FAIL lock_drop: got %h want 02", gnt); end
  endtask
`endif

  task automatic test_random();
    do_reset(7'h00);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) req = 7'($urandom);
      else if ($urandom_range(2) == 0) req[$urandom_range(6)] = ~req[$urandom_range(6)];
`ifdef ARB_LOCK_EN
      if ($urandom_range(5) == 0) lock = ~lock;
`endif
      #1;
      total++;
      if (any_req !== (req != 7'h00)) begin
        bad++; $display("FAIL rnd_anyreq c%0d: got %b want %b", c, any_req, req != 7'h00);
      end
      tick();
      total++;
      if (gnt !== m_gnt() || gnt_id !== m_id() || gnt_valid !== (m_owner >= 0)) begin
        bad++;
        $display("FAIL rnd_grant c%0d: got gnt %h id %0d valid %b want gnt %h id %0d valid %b",
                 c, gnt, gnt_id, gnt_valid, m_gnt(), m_id(), m_owner >= 0);
      end
      total++;
      if (!$onehot0(gnt)) begin bad++; $display("FAIL rnd_onehot c%0d: got %h want one-hot or zero", c, gnt); end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_timeout();
    test_sole();
    test_async_reset();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
